link_rx_buffer: RTL and testbench

LINK_RX_BUFFER -- requirements
Module: link_rx_buffer

---
 rtl/link_rx_buffer.sv | 114 +++++++++++
 tb/tb_link_rx_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_rx_buffer.sv
// rtl/link_rx_buffer.sv - 4-phase receive handshake feeding a first-word-fall-through FIFO
// Optional macro LINK_RX_SYNC_EN: double-flop synchronizer on i_req_rx for an asynchronous link.
module link_rx_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] di_1_to_2,
    input  logic        i_req_rx,
    output logic        o_ack_rx,
    output logic        o_rdy_rx,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_words
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [15:0]     words;
    logic            req_s;
    logic            full;
    logic            push;
    logic            pop;

`ifdef LINK_RX_SYNC_EN
    logic req_meta;
    logic req_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_meta <= 1'b0;
            req_sync <= 1'b0;
        end else begin
            req_meta <= i_req_rx;
            req_sync <= req_meta;
        end
    end

    assign req_s = req_sync;
`else
    assign req_s = i_req_rx;
`endif

    // Full comes from the registered count, so a pop on the same edge cannot open room for a push.
    assign full = (count == FULL_COUNT);
    assign pop  = (count != '0) && i_ready;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && en && !full) begin
                    state_nxt = ACK;
                    push      = 1'b1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            words  <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                words  <= words + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; o_data is gated by o_valid so stale words never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= di_1_to_2;
        end
    end

    assign o_ack_rx = (state == ACK);
    assign o_valid  = (count != '0);
    assign o_data   = o_valid ? mem[rd_ptr] : 32'h0;
    assign o_rdy_rx = rst && en && !full;
    assign o_words  = words;

endmodule

// File: tb/tb_link_rx_buffer.sv
// tb/tb_link_rx_buffer.sv - directed scoreboard bench for link_rx_buffer
module tb_link_rx_buffer;
    localparam int DEPTH = 4;
`ifdef LINK_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] di_1_to_2 = 32'h0;
    logic        i_req_rx = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ack_rx;
    logic        o_rdy_rx;
    logic [31:0] o_data;
    logic        o_valid;
    logic [15:0] o_words;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];
    logic [31:0] cur_word = 32'h0;
    logic [15:0] exp_words = 16'h0;

    always #5 clk = ~clk;

    link_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .di_1_to_2 (di_1_to_2),
        .i_req_rx  (i_req_rx),
        .o_ack_rx  (o_ack_rx),
        .o_rdy_rx  (o_rdy_rx),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_words   (o_words)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Consumer side: every edge that will pop is checked against the scoreboard head.
    always @(negedge clk) begin
        #3;
        if (o_valid && i_ready) begin
            check_int("pop_sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                check32("pop_data", o_data, sb.pop_front());
            end
        end
    end

    task automatic raise(input logic [31:0] w);
        @(negedge clk);
        di_1_to_2 = w;
        cur_word  = w;
        i_req_rx  = 1'b1;
    endtask

    task automatic wait_ack(input string tag, input int budget, output int n);
        n = 0;
        while (n < budget && !o_ack_rx) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int(tag, int'(o_ack_rx), 1);
    endtask

    task automatic accept();
        if (o_ack_rx) begin
            sb.push_back(cur_word);
            exp_words = exp_words + 16'd1;
            check32("words_count", {16'h0, o_words}, {16'h0, exp_words});
        end
    endtask

    task automatic drop(input string tag);
        int n;
        @(negedge clk);
        i_req_rx = 1'b0;
        n = 0;
        while (n < 10 && o_ack_rx) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int(tag, n, LAT);
    endtask

    task automatic handshake(input logic [31:0] w);
        int n;
        raise(w);
        wait_ack("hs_ack", 10, n);
        check_int("hs_latency", n, LAT);
        accept();
        drop("hs_ack_fall");
    endtask

    task automatic drain(input int k);
        @(negedge clk);
        i_ready = 1'b1;
        repeat (k) @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic push_pop(input logic [31:0] w);
        raise(w);
        repeat (LAT - 1) @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check_int("pp_ack", int'(o_ack_rx), 1);
        accept();
        check_int("pp_count", int'(dut.count), sb.size());
        @(negedge clk);
        i_ready = 1'b0;
        drop("pp_ack_fall");
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] words8 [6];
        words8 = '{32'h11110001, 32'h22220002, 32'h33330003,
                   32'h44440004, 32'h55550005, 32'h66660006};

        // Reset state, with en already high to show o_rdy_rx is held low.
        en = 1'b1;
        #2;
        check32("rst_ack", {31'h0, o_ack_rx}, 32'h0);
        check32("rst_valid", {31'h0, o_valid}, 32'h0);
        check32("rst_rdy", {31'h0, o_rdy_rx}, 32'h0);
        check32("rst_words", {16'h0, o_words}, 32'h0);
        check32("rst_data", o_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check32("rdy_after_rst", {31'h0, o_rdy_rx}, 32'h1);

        // Single word
        raise(32'hE6B058F1);
        wait_ack("t1_ack", 10, n);
        check_int("t1_latency", n, LAT);
        accept();
        check32("t1_data", o_data, 32'hE6B058F1);
        check32("t1_valid", {31'h0, o_valid}, 32'h1);
        drop("t1_ack_fall");
        drain(1);
        check32("t1_empty", {31'h0, o_valid}, 32'h0);

        // Fill and backpressure
        handshake(32'hA0000001);
        handshake(32'hA0000002);
        handshake(32'hA0000003);
        handshake(32'hA0000004);
        check32("t2_rdy_full", {31'h0, o_rdy_rx}, 32'h0);
        check_int("t2_count_full", int'(dut.count), DEPTH);
        raise(32'hF4A91D5D);
        repeat (6) @(posedge clk);
        #1;
        check32("t2_no_ack_full", {31'h0, o_ack_rx}, 32'h0);
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        wait_ack("t2_ack_after_pop", 4, n);
        check_int("t2_latency_after_pop", n, 1);
        accept();
        drop("t2_ack_fall");
        drain(4);
        check32("t2_empty", {31'h0, o_valid}, 32'h0);

        // Simultaneous push and pop at count 2, with pointer wrap
        handshake(32'hB0000001);
        handshake(32'hB0000002);
        for (int i = 0; i < 6; i++) begin
            push_pop(words8[i]);
        end
        drain(2);
        check32("t3_empty", {31'h0, o_valid}, 32'h0);

        // Enable gating
        @(negedge clk);
        en = 1'b0;
        raise(32'h5068431D);
        repeat (5) @(posedge clk);
        #1;
        check32("t4_no_ack_en0", {31'h0, o_ack_rx}, 32'h0);
        check32("t4_rdy_en0", {31'h0, o_rdy_rx}, 32'h0);
        @(negedge clk);
        en = 1'b1;
        wait_ack("t4_ack_en1", 6, n);
        accept();
        drop("t4_ack_fall");
        drain(1);

        // Reset during ACK with 3 words buffered
        handshake(32'hC0000001);
        handshake(32'hC0000002);
        raise(32'hC0000003);
        wait_ack("t5_ack", 10, n);
        accept();
        check_int("t5_count3", int'(dut.count), 3);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check32("t5_rst_ack", {31'h0, o_ack_rx}, 32'h0);
        check32("t5_rst_valid", {31'h0, o_valid}, 32'h0);
        check32("t5_rst_words", {16'h0, o_words}, 32'h0);
        check32("t5_rst_data", o_data, 32'h0);
        sb.delete();
        exp_words = 16'h0;
        @(negedge clk);
        rst = 1'b1;
        wait_ack("t5_fresh_ack", 10, n);
        accept();
        drop("t5_ack_fall");
        drain(1);
        check32("t5_empty", {31'h0, o_valid}, 32'h0);

        // o_words wrap: counter preloaded just below the wrap point
        @(negedge clk);
        dut.words = 16'hFFFD;
        exp_words = 16'hFFFD;
        handshake(32'hD0000001);
        handshake(32'hD0000002);
        check32("t6_words_ffff", {16'h0, o_words}, 32'h0000FFFF);
        handshake(32'hD0000003);
        check32("t6_words_wrap", {16'h0, o_words}, 32'h0);
        handshake(32'hD0000004);
        drain(4);
        check32("t6_empty", {31'h0, o_valid}, 32'h0);
        check_int("t6_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
